decryption_dispatcher: RTL and testbench

- Sequences the decryption datapath: routes the incoming ciphertext character stream to one of three decryption engines (caesar, scytale, zigzag), based on the `select` value programmed in the decryption register file.
- Locks the chosen engine for a whole message, back-pressures upstream while the engine drains, and merges the engine results onto one output stream.
- Sits between the input stream source, the three engines and the output sink.

---
 rtl/decryption_pkg.sv | 38 +++
 rtl/decryption_dispatcher_if.sv | 28 ++
 rtl/decryption_result_mux.sv | 50 +++++
 rtl/decryption_dispatcher.sv | 116 +++++++++++
 tb/tb_decryption_dispatcher.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/decryption_pkg.sv
// Shared encodings for the decryption datapath: engine select values, dispatcher
// states and the default message terminator.
package decryption_pkg;

    localparam int unsigned D_WIDTH_DEF   = 8;
    localparam logic [7:0]  TERM_CHAR_DEF = 8'hFA;

    localparam logic [1:0] SEL_CAESAR  = 2'd0;
    localparam logic [1:0] SEL_SCYTALE = 2'd1;
    localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
    localparam logic [1:0] SEL_INVALID = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Picks one engine's bit out of a per-engine vector; the invalid select reads as 0.
    function automatic logic sel_bit(input logic [2:0] vec, input logic [1:0] sel);
        case (sel)
            SEL_CAESAR:  return vec[0];
            SEL_SCYTALE: return vec[1];
            SEL_ZIGZAG:  return vec[2];
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            SEL_CAESAR:  return 3'b001;
            SEL_SCYTALE: return 3'b010;
            SEL_ZIGZAG:  return 3'b100;
            default:     return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/decryption_dispatcher_if.sv
// Stream, engine and result signals of the decryption dispatcher. Handshake: the
// source may raise valid_i only while busy_o is low; engine and result valids are single-cycle strobes.
interface decryption_dispatcher_if #(
    parameter int unsigned D_WIDTH = 8
);
    logic [1:0]           select;
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic                 busy_o;
    logic [D_WIDTH-1:0]   eng_data_o;
    logic [2:0]           eng_valid_o;
    logic [2:0]           eng_busy_i;
    logic [3*D_WIDTH-1:0] eng_res_data_i;
    logic [2:0]           eng_res_valid_i;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;
    logic                 err_o;

    modport slave (
        input  select, data_i, valid_i, eng_busy_i, eng_res_data_i, eng_res_valid_i,
        output busy_o, eng_data_o, eng_valid_o, data_o, valid_o, err_o
    );

    modport master (
        output select, data_i, valid_i, eng_busy_i, eng_res_data_i, eng_res_valid_i,
        input  busy_o, eng_data_o, eng_valid_o, data_o, valid_o, err_o
    );
endinterface

// File: rtl/decryption_result_mux.sv
// Registered 3:1 merge of engine results; only the engine locked for the current
// message is forwarded, and nothing is forwarded while idle.
module decryption_result_mux
    import decryption_pkg::*;
#(
    parameter int unsigned D_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  state_t               state_i,
    input  logic [1:0]           active_sel_i,
    input  logic [3*D_WIDTH-1:0] res_data_i,
    input  logic [2:0]           res_valid_i,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    logic [D_WIDTH-1:0] sel_data;
    logic               hit;
    logic [D_WIDTH-1:0] data_q;
    logic               valid_q;

    always_comb begin
        sel_data = '0;
        case (active_sel_i)
            SEL_CAESAR:  sel_data = res_data_i[0*D_WIDTH +: D_WIDTH];
            SEL_SCYTALE: sel_data = res_data_i[1*D_WIDTH +: D_WIDTH];
            SEL_ZIGZAG:  sel_data = res_data_i[2*D_WIDTH +: D_WIDTH];
            default:     sel_data = '0;
        endcase
    end

    assign hit = (state_i != ST_IDLE) && sel_bit(res_valid_i, active_sel_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= hit;
            if (hit) begin
                data_q <= sel_data;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/decryption_dispatcher.sv
// Routes a ciphertext stream to the engine chosen at message start, holds that
// engine until it drains, and merges its results onto one output stream.
module decryption_dispatcher
    import decryption_pkg::*;
#(
    parameter int unsigned        D_WIDTH       = D_WIDTH_DEF,
    parameter logic [D_WIDTH-1:0] TERM_CHAR     = D_WIDTH'(TERM_CHAR_DEF),
    parameter int unsigned        DRAIN_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    decryption_dispatcher_if.slave  bus,
    output state_t                  state_o
);

    localparam int unsigned     CW        = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DRAIN_TIMEOUT - 1);

    state_t             state_q;
    logic [1:0]         active_sel_q;
    logic [CW-1:0]      drain_cnt_q;
    logic               busy_seen_q;
    logic [2:0]         eng_valid_q;
    logic [D_WIDTH-1:0] eng_data_q;
    logic               err_q;

    logic eng_busy_act;
    logic busy;
    logic accept;
    logic is_term;

    assign eng_busy_act = sel_bit(bus.eng_busy_i, active_sel_q);
    assign busy         = (state_q == ST_DRAIN) || ((state_q == ST_STREAM) && eng_busy_act);
    assign accept       = bus.valid_i && !busy;
    assign is_term      = (bus.data_i == TERM_CHAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            active_sel_q <= SEL_CAESAR;
            drain_cnt_q  <= '0;
            busy_seen_q  <= 1'b0;
            eng_valid_q  <= '0;
            eng_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            eng_valid_q <= '0;
            err_q       <= bus.valid_i && busy;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.select == SEL_INVALID) begin
                            err_q <= 1'b1;
                        end else begin
                            eng_valid_q  <= sel_onehot(bus.select);
                            eng_data_q   <= bus.data_i;
                            active_sel_q <= bus.select;
                            if (is_term) begin
                                state_q     <= ST_DRAIN;
                                drain_cnt_q <= '0;
                                busy_seen_q <= 1'b0;
                            end else begin
                                state_q <= ST_STREAM;
                            end
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        eng_valid_q <= sel_onehot(active_sel_q);
                        eng_data_q  <= bus.data_i;
                        if (is_term) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                            busy_seen_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave on the falling busy edge, or give up if the engine never started.
                    if (busy_seen_q) begin
                        if (!eng_busy_act) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (eng_busy_act) begin
                        busy_seen_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CW'(1);
                        if (drain_cnt_q == CNT_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    decryption_result_mux #(.D_WIDTH(D_WIDTH)) u_result_mux (
        .clk          (clk),
        .rst_n        (rst_n),
        .state_i      (state_q),
        .active_sel_i (active_sel_q),
        .res_data_i   (bus.eng_res_data_i),
        .res_valid_i  (bus.eng_res_valid_i),
        .data_o       (bus.data_o),
        .valid_o      (bus.valid_o)
    );

    assign bus.busy_o      = busy;
    assign bus.eng_valid_o = eng_valid_q;
    assign bus.eng_data_o  = eng_data_q;
    assign bus.err_o       = err_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Directed bench for decryption_dispatcher: stimulus pushes expected engine
// dispatches, results and error pulses; a negedge monitor pops and compares them.
module tb_decryption_dispatcher;
    import decryption_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state;

    always #5 clk = ~clk;

    decryption_dispatcher_if #(.D_WIDTH(W)) bus();

    decryption_dispatcher #(
        .D_WIDTH       (W),
        .TERM_CHAR     (8'hFA),
        .DRAIN_TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state)
    );

    int checks = 0;
    int errors = 0;

    logic [W+2:0] exp_eng_q[$];
    logic [W-1:0] exp_res_q[$];
    logic         exp_err_q[$];
    logic [W+2:0] mon_eng;
    logic [W-1:0] mon_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] ch, input logic [2:0] onehot, input logic exp_err);
        if (onehot != 3'b000) exp_eng_q.push_back({onehot, ch});
        if (exp_err) exp_err_q.push_back(1'b1);
        bus.data_i  = ch;
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (state != ST_IDLE && n < bound) begin
            step();
            n++;
        end
        check("idle_reached", 32'(state == ST_IDLE), 32'd1);
    endtask

    // Monitor: every presented output must match the head of its expected queue.
    always @(negedge clk) begin
        if (bus.eng_valid_o != 3'b000) begin
            if (exp_eng_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL eng_unexpected: got valid %b data %h, expected no dispatch", bus.eng_valid_o, bus.eng_data_o);
            end else begin
                mon_eng = exp_eng_q.pop_front();
                check("eng_dispatch", 32'({bus.eng_valid_o, bus.eng_data_o}), 32'(mon_eng));
            end
        end
        if (bus.valid_o) begin
            if (exp_res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL res_unexpected: got data_o %h, expected no result", bus.data_o);
            end else begin
                mon_res = exp_res_q.pop_front();
                check("res_merge", 32'(bus.data_o), 32'(mon_res));
            end
        end
        if (bus.err_o) begin
            if (exp_err_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL err_unexpected: got err_o 1, expected 0");
            end else begin
                void'(exp_err_q.pop_front());
                check("err_pulse", 32'(bus.err_o), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.select          = 2'd0;
        bus.data_i          = '0;
        bus.valid_i         = 1'b0;
        bus.eng_busy_i      = 3'b000;
        bus.eng_res_data_i  = '0;
        bus.eng_res_valid_i = 3'b000;

        rst_n = 1'b0;
        repeat (2) step();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_eng_valid", 32'(bus.eng_valid_o), 32'd0);
        check("rst_eng_data", 32'(bus.eng_data_o), 32'd0);
        check("rst_outputs", 32'({bus.data_o, bus.valid_o, bus.err_o}), 32'd0);
        rst_n = 1'b1;
        step();

        // Caesar message; engine 0 busy for two cycles after the terminator.
        bus.select = 2'd0;
        send(8'h41, 3'b001, 1'b0);
        check("caesar_stream", 32'(state), 32'(ST_STREAM));
        send(8'h42, 3'b001, 1'b0);
        send(8'hFA, 3'b001, 1'b0);
        check("caesar_drain", 32'(state), 32'(ST_DRAIN));
        check("caesar_drain_busy", 32'(bus.busy_o), 32'd1);
        bus.eng_busy_i = 3'b001;
        step();
        check("caesar_busy_hi1", 32'({state, bus.busy_o}), 32'({ST_DRAIN, 1'b1}));
        step();
        check("caesar_busy_hi2", 32'({state, bus.busy_o}), 32'({ST_DRAIN, 1'b1}));
        bus.eng_busy_i = 3'b000;
        step();
        check("caesar_idle", 32'({state, bus.busy_o}), 32'({ST_IDLE, 1'b0}));

        // Select change mid-message stays on scytale; result merge in DRAIN.
        bus.select = 2'd1;
        send(8'h58, 3'b010, 1'b0);
        bus.select = 2'd2;
        send(8'h59, 3'b010, 1'b0);
        send(8'hFA, 3'b010, 1'b0);
        bus.eng_res_data_i  = {8'h7A, 8'h61, 8'h00};
        bus.eng_res_valid_i = 3'b110;
        exp_res_q.push_back(8'h61);
        step();
        bus.eng_res_valid_i = 3'b000;
        check("merge_valid", 32'(bus.valid_o), 32'd1);
        check("merge_data", 32'(bus.data_o), 32'h61);
        step();
        check("merge_hold", 32'({bus.valid_o, bus.data_o}), 32'({1'b0, 8'h61}));
        check("timeout_drain", 32'(state), 32'(ST_DRAIN));
        step();
        check("timeout_drain3", 32'(state), 32'(ST_DRAIN));
        step();
        check("timeout_idle", 32'(state), 32'(ST_IDLE));
        bus.eng_res_data_i  = {8'h00, 8'h55, 8'h00};
        bus.eng_res_valid_i = 3'b010;
        step();
        bus.eng_res_valid_i = 3'b000;
        check("idle_res_ignored", 32'(bus.valid_o), 32'd0);

        // Back-pressure drop in STREAM and drop in DRAIN.
        bus.select = 2'd0;
        send(8'h43, 3'b001, 1'b0);
        bus.eng_busy_i = 3'b001;
        #1;
        check("bp_busy", 32'(bus.busy_o), 32'd1);
        send(8'h41, 3'b000, 1'b1);
        check("bp_err", 32'(bus.err_o), 32'd1);
        check("bp_state", 32'(state), 32'(ST_STREAM));
        bus.eng_busy_i = 3'b000;
        step();
        check("bp_err_pulse", 32'(bus.err_o), 32'd0);
        send(8'hFA, 3'b001, 1'b0);
        send(8'h44, 3'b000, 1'b1);
        check("drain_drop_state", 32'(state), 32'(ST_DRAIN));
        wait_idle(6);

        // Invalid select in IDLE.
        bus.select = 2'd3;
        send(8'h41, 3'b000, 1'b1);
        check("inv_state", 32'(state), 32'(ST_IDLE));
        check("inv_err", 32'(bus.err_o), 32'd1);

        // Terminator straight from IDLE on zigzag; busy never rises.
        bus.select = 2'd2;
        send(8'hFA, 3'b100, 1'b0);
        check("to_busy0", 32'({state, bus.busy_o}), 32'({ST_DRAIN, 1'b1}));
        for (int i = 1; i < 4; i++) begin
            step();
            check("to_busy_n", 32'({state, bus.busy_o}), 32'({ST_DRAIN, 1'b1}));
        end
        step();
        check("to_exit", 32'({state, bus.busy_o}), 32'({ST_IDLE, 1'b0}));

        // Reset in the middle of a message.
        bus.select = 2'd0;
        send(8'h41, 3'b001, 1'b0);
        check("pre_rst_stream", 32'(state), 32'(ST_STREAM));
        bus.data_i  = 8'h42;
        bus.valid_i = 1'b1;
        rst_n       = 1'b0;
        step();
        bus.valid_i = 1'b0;
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        check("mid_rst_eng", 32'({bus.eng_valid_o, bus.eng_data_o}), 32'd0);
        check("mid_rst_out", 32'({bus.data_o, bus.valid_o, bus.err_o, bus.busy_o}), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        check("eng_q_empty", 32'(exp_eng_q.size()), 32'd0);
        check("res_q_empty", 32'(exp_res_q.size()), 32'd0);
        check("err_q_empty", 32'(exp_err_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
